regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 9 +
 rtl/regfile_scoreboard_core.sv | 36 +++
 rtl/regfile_scoreboard.sv | 65 ++++++
 tb/tb_regfile_scoreboard.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared widths, FSM state type and dedicated register indices
package regfile_scoreboard_pkg;
  localparam int REG_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [ADDR_W-1:0] STATUS_REG = 5'd30;
  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;
  typedef enum logic {IDLE, PEND} state_t;
endpackage

// File: rtl/regfile_scoreboard_core.sv
// regfile_core: register array with two write ports and write-through reads; md port wins on conflict
module regfile_core
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_en,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_en,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (pipe_en && pipe_addr != ZERO_REG) regs[pipe_addr] <= pipe_data;
      if (md_en && md_addr != ZERO_REG) regs[md_addr] <= md_data;
    end
  end
  assign rd_a = rd_a_addr == ZERO_REG ? '0 :
                md_en && md_addr == rd_a_addr ? md_data :
                pipe_en && pipe_addr == rd_a_addr ? pipe_data : regs[rd_a_addr];
  assign rd_b = rd_b_addr == ZERO_REG ? '0 :
                md_en && md_addr == rd_b_addr ? md_data :
                pipe_en && pipe_addr == rd_b_addr ? pipe_data : regs[rd_b_addr];
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with a single-entry mult/div scoreboard and decode stall
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_dest,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_result,
  output logic              md_busy,
  output logic              stall
);
  state_t state, state_next;
  logic [ADDR_W-1:0] pend_reg, pend_next;
  logic take, md_write;
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
      pend_reg <= '0;
    end else begin
      state <= state_next;
      pend_reg <= pend_next;
    end
  end
  // A new issue is only accepted from IDLE or in the cycle the pending op retires
  always_comb begin
    state_next = state;
    pend_next = pend_reg;
    take = md_issue && md_dest != ZERO_REG;
    if (state == IDLE || md_done) begin
      state_next = take ? PEND : IDLE;
      pend_next = take ? md_dest : pend_reg;
    end
  end
  assign md_busy = state == PEND;
  assign md_write = md_busy && md_done;
  assign stall = md_busy && !md_done &&
                 (ctrl_readRegA == pend_reg || ctrl_readRegB == pend_reg ||
                  (ctrl_writeEnable && ctrl_writeReg == pend_reg));
  regfile_core #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_core (
    .clk(clock),
    .rst(ctrl_reset),
    .pipe_en(ctrl_writeEnable),
    .pipe_addr(ctrl_writeReg),
    .pipe_data(data_writeReg),
    .md_en(md_write),
    .md_addr(pend_reg),
    .md_data(md_result),
    .rd_a_addr(ctrl_readRegA),
    .rd_b_addr(ctrl_readRegB),
    .rd_a(data_readRegA),
    .rd_b(data_readRegB)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus random traffic against a behavioural model
module tb_regfile_scoreboard;
  logic clock = 0;
  always #5 clock = ~clock;
  logic ctrl_reset, ctrl_writeEnable, md_issue, md_done, md_busy, stall;
  logic [4:0] ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, md_dest;
  logic [31:0] data_writeReg, md_result, data_readRegA, data_readRegB;
  int errors = 0, checks = 0;
  logic [31:0] mem [32];
  logic busy;
  logic [4:0] pend;

  regfile_scoreboard dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .md_issue(md_issue), .md_dest(md_dest), .md_done(md_done),
    .md_result(md_result), .md_busy(md_busy), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set(input logic rst, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic iss,
                     input logic [4:0] dst, input logic dn, input logic [31:0] res);
    ctrl_reset = rst; ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    ctrl_readRegA = ra; ctrl_readRegB = rb; md_issue = iss; md_dest = dst;
    md_done = dn; md_result = res;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (busy && md_done && a == pend) return md_result;
    if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
    return mem[a];
  endfunction

  task automatic update_model();
    if (ctrl_reset) begin
      foreach (mem[i]) mem[i] = 0;
      busy = 0;
      pend = 0;
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) mem[ctrl_writeReg] = data_writeReg;
      if (busy && md_done) mem[pend] = md_result;
      if (!busy || md_done) begin
        busy = md_issue && md_dest != 0;
        if (busy) pend = md_dest;
      end
    end
  endtask

  task automatic tick();
    logic exp_stall;
    @(negedge clock);
    exp_stall = busy && !md_done && (ctrl_readRegA == pend || ctrl_readRegB == pend ||
                (ctrl_writeEnable && ctrl_writeReg == pend));
    check("rd_a", data_readRegA, exp_rd(ctrl_readRegA));
    check("rd_b", data_readRegB, exp_rd(ctrl_readRegB));
    check("md_busy", {31'b0, md_busy}, {31'b0, busy});
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    @(posedge clock);
    update_model();
    #1;
  endtask

  initial begin
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    update_model();
    #1;
    set(0, 0, 0, 0, 5, 31, 0, 0, 0, 0);
    #1 check("rst_busy", {31'b0, md_busy}, 32'd0);
    check("rst_r5", data_readRegA, 0);
    check("rst_r31", data_readRegB, 0);
    tick();
    set(0, 1, 5, 32'hdeadbeef, 5, 0, 0, 0, 0, 0);
    #1 check("fwd_r5", data_readRegA, 32'hdeadbeef);
    tick();
    set(0, 0, 0, 0, 5, 5, 0, 0, 0, 0);
    #1 check("hold_r5", data_readRegB, 32'hdeadbeef);
    tick();
    set(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    #1 check("r0_fwd_a", data_readRegA, 0);
    check("r0_fwd_b", data_readRegB, 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("r0_hold", data_readRegA, 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    set(0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    #1 check("r7_stall", {31'b0, stall}, 1);
    check("r7_busy", {31'b0, md_busy}, 1);
    tick();
    set(0, 0, 0, 0, 7, 0, 0, 0, 1, 32'h55);
    #1 check("done_nostall", {31'b0, stall}, 0);
    check("done_fwd", data_readRegA, 32'h55);
    tick();
    set(0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    #1 check("done_idle", {31'b0, md_busy}, 0);
    check("r7_hold", data_readRegA, 32'h55);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    tick();
    set(0, 1, 9, 32'h11, 9, 0, 0, 0, 1, 32'h22);
    #1 check("collide_fwd", data_readRegA, 32'h22);
    tick();
    set(0, 0, 0, 0, 9, 0, 0, 0, 0, 0);
    #1 check("collide_store", data_readRegA, 32'h22);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    tick();
    set(0, 0, 0, 0, 6, 0, 1, 6, 1, 32'h44);
    tick();
    set(0, 0, 0, 0, 6, 4, 0, 0, 0, 0);
    #1 check("reissue_busy", {31'b0, md_busy}, 1);
    check("reissue_stall", {31'b0, stall}, 1);
    check("reissue_r4", data_readRegB, 32'h44);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set(0, 0, 0, 0, 3, 5, 0, 0, 1, 32'h99);
    #1 check("abandon_busy", {31'b0, md_busy}, 0);
    check("abandon_fwd", data_readRegA, 0);
    check("abandon_r5", data_readRegB, 0);
    tick();
    set(0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    #1 check("abandon_r3", data_readRegA, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      set($urandom_range(0, 80) == 0, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
          $urandom,
          5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
          5'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, $urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
